// File: rtl/rv_pkg.sv
// Shared constants and types for the branch predictor: opcode match, counter
// reset value, flush encodings and the recovery FSM state.
package rv_pkg;

  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [1:0] BHT_INIT   = 2'b01;
  localparam logic [1:0] FLUSH_ALL  = 2'b11;
  localparam logic [1:0] FLUSH_NONE = 2'b00;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    FLUSH = 1'b1
  } bp_state_t;

endpackage

// File: rtl/bht_table.sv
// Branch history table: array of 2-bit saturating counters with one
// combinational read port and one saturating update port.
module bht_table
  import rv_pkg::*;
#(
  parameter int ENTRIES = 16,
  parameter int IDX_W   = $clog2(ENTRIES)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX_W-1:0] rd_idx_i,
  output logic [1:0]       rd_cnt_o,
  input  logic             upd_en_i,
  input  logic [IDX_W-1:0] upd_idx_i,
  input  logic             upd_taken_i
);

  logic [1:0] cnt_q [ENTRIES];
  logic [1:0] upd_cur;
  logic [1:0] upd_nxt;

  // The read sees the stored value, so a same-cycle update is not bypassed.
  assign rd_cnt_o = cnt_q[rd_idx_i];
  assign upd_cur  = cnt_q[upd_idx_i];

  always_comb begin
    upd_nxt = upd_cur;
    if (upd_taken_i) begin
      if (upd_cur != 2'b11) upd_nxt = upd_cur + 2'b01;
    end else begin
      if (upd_cur != 2'b00) upd_nxt = upd_cur - 2'b01;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) cnt_q[i] <= BHT_INIT;
    end else if (upd_en_i) begin
      cnt_q[upd_idx_i] <= upd_nxt;
    end
  end

endmodule

// File: rtl/branch_pred_ctrl.sv
// Dynamic branch predictor and mispredict recovery controller: predicts in IF,
// carries the prediction to EX, and sequences a one-cycle redirect/flush.
module branch_pred_ctrl
  import rv_pkg::*;
#(
  parameter int BHT_ENTRIES = 16,
  parameter int XLEN        = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            if_valid,
  input  logic [XLEN-1:0] if_pc,
  input  logic [XLEN-1:0] if_inst,
  input  logic            ex_valid,
  input  logic            ex_is_branch,
  input  logic [XLEN-1:0] ex_pc,
  input  logic            ex_taken,
  input  logic [XLEN-1:0] ex_target,
  output logic            pred_taken,
  output logic            pc_sel,
  output logic [XLEN-1:0] redirect_pc,
  output logic [1:0]      flush,
  output logic [15:0]     miss_cnt,
  output bp_state_t       dbg_state
);

  localparam int IDX_W = $clog2(BHT_ENTRIES);

  logic            id_pred_q, id_vld_q, ex_pred_q, ex_vld_q;
  bp_state_t       state_q;
  logic            pc_sel_q;
  logic [1:0]      flush_q;
  logic [XLEN-1:0] redirect_q, redirect_d;
  logic [15:0]     miss_cnt_q, miss_cnt_d;
  logic [1:0]      rd_cnt;
  logic            res, miss;
  logic            unused_bits;

  bht_table #(
    .ENTRIES(BHT_ENTRIES),
    .IDX_W  (IDX_W)
  ) u_bht (
    .clk        (clk),
    .rst        (rst),
    .rd_idx_i   (if_pc[IDX_W+1:2]),
    .rd_cnt_o   (rd_cnt),
    .upd_en_i   (res),
    .upd_idx_i  (ex_pc[IDX_W+1:2]),
    .upd_taken_i(ex_taken)
  );

  assign pred_taken = if_valid && (if_inst[6:0] == OPC_BRANCH) && rd_cnt[1];

  // Branches seen during FLUSH are on the wrong path and must not train or redirect.
  assign res  = ex_valid && ex_is_branch && !stall && (state_q == IDLE);
  assign miss = res && (ex_pred_q != ex_taken);

  assign redirect_d = ex_taken ? ex_target : ex_pc + XLEN'(4);
  assign miss_cnt_d = (miss_cnt_q == 16'hFFFF) ? miss_cnt_q : miss_cnt_q + 16'd1;

  always_ff @(posedge clk) begin
    if (rst || (flush_q != FLUSH_NONE)) begin
      id_pred_q <= 1'b0;
      id_vld_q  <= 1'b0;
      ex_pred_q <= 1'b0;
      ex_vld_q  <= 1'b0;
    end else if (!stall) begin
      id_pred_q <= pred_taken;
      id_vld_q  <= if_valid;
      ex_pred_q <= id_pred_q;
      ex_vld_q  <= id_vld_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      pc_sel_q   <= 1'b0;
      flush_q    <= FLUSH_NONE;
      redirect_q <= '0;
      miss_cnt_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (miss) begin
            state_q    <= FLUSH;
            pc_sel_q   <= 1'b1;
            flush_q    <= FLUSH_ALL;
            redirect_q <= redirect_d;
            miss_cnt_q <= miss_cnt_d;
          end
        end
        FLUSH: begin
          state_q  <= IDLE;
          pc_sel_q <= 1'b0;
          flush_q  <= FLUSH_NONE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign pc_sel      = pc_sel_q;
  assign flush       = flush_q;
  assign redirect_pc = redirect_q;
  assign miss_cnt    = miss_cnt_q;
  assign dbg_state   = state_q;

  assign unused_bits = ^{if_pc[XLEN-1:IDX_W+2], if_pc[1:0], if_inst[XLEN-1:7], ex_vld_q};

endmodule

// File: tb/tb_branch_pred_ctrl.sv
// Bench for branch_pred_ctrl: hand-derived vector table for the directed
// scenarios, a wrap-around sequence, and random traffic against a reference model.
module tb_branch_pred_ctrl;

  localparam logic [31:0] BR  = 32'h0000_0063;
  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam int          EW  = 51;

  logic        clk = 1'b0;
  logic        rst, stall, if_valid, ex_valid, ex_is_branch, ex_taken;
  logic [31:0] if_pc, if_inst, ex_pc, ex_target;
  logic        pred_taken, pc_sel;
  logic [31:0] redirect_pc;
  logic [1:0]  flush;
  logic [15:0] miss_cnt;
  rv_pkg::bp_state_t dbg_state;

  always #5 clk = ~clk;

  branch_pred_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .stall       (stall),
    .if_valid    (if_valid),
    .if_pc       (if_pc),
    .if_inst     (if_inst),
    .ex_valid    (ex_valid),
    .ex_is_branch(ex_is_branch),
    .ex_pc       (ex_pc),
    .ex_taken    (ex_taken),
    .ex_target   (ex_target),
    .pred_taken  (pred_taken),
    .pc_sel      (pc_sel),
    .redirect_pc (redirect_pc),
    .flush       (flush),
    .miss_cnt    (miss_cnt),
    .dbg_state   (dbg_state)
  );

  typedef struct {
    logic        rst, stall, ifv;
    logic [31:0] ifpc, ifinst;
    logic        exv, exbr;
    logic [31:0] expc;
    logic        ext;
    logic [31:0] extgt;
    logic        e_pred, e_pc_sel;
    logic [1:0]  e_flush;
    logic [31:0] e_redir;
    logic [15:0] e_miss;
    logic [1:0]  e_cnt0;
  } vec_t;

  int checks   = 0;
  int failures = 0;

  // Reference model: counters as small integers, a two-slot prediction pipe,
  // and a flag for the single recovery cycle.
  int          m_bht [16];
  bit          m_id_pred, m_ex_pred, m_flushing, m_pc_sel;
  logic [1:0]  m_flush;
  logic [31:0] m_redir;
  logic [15:0] m_miss;
  logic [EW-1:0] exp_q[$];

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_bht[i] = 1;
    m_id_pred = 0; m_ex_pred = 0; m_flushing = 0; m_pc_sel = 0;
    m_flush = 2'b00; m_redir = '0; m_miss = '0;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic r, s, ifv, input logic [31:0] ifpc, ifinst,
                              input logic exv, exbr, input logic [31:0] expc,
                              input logic ext, input logic [31:0] extgt,
                              input logic e_pred, e_pc_sel, input logic [1:0] e_flush,
                              input logic [31:0] e_redir, input logic [15:0] e_miss,
                              input logic [1:0] e_cnt0);
    vec_t v;
    v.rst = r; v.stall = s; v.ifv = ifv; v.ifpc = ifpc; v.ifinst = ifinst;
    v.exv = exv; v.exbr = exbr; v.expc = expc; v.ext = ext; v.extgt = extgt;
    v.e_pred = e_pred; v.e_pc_sel = e_pc_sel; v.e_flush = e_flush;
    v.e_redir = e_redir; v.e_miss = e_miss; v.e_cnt0 = e_cnt0;
    return v;
  endfunction

  // Applies one cycle of inputs (entered at a falling edge), checks the
  // combinational prediction, advances the model, then checks registered state.
  task automatic drive(input vec_t v, input bit use_tbl);
    bit            exp_pred, res, miss;
    int            ei;
    logic [EW-1:0] e;
    logic [31:0]   act_bht, exp_bht;
    rst = v.rst; stall = v.stall; if_valid = v.ifv; if_pc = v.ifpc; if_inst = v.ifinst;
    ex_valid = v.exv; ex_is_branch = v.exbr; ex_pc = v.expc; ex_taken = v.ext;
    ex_target = v.extgt;
    #1;
    exp_pred = v.ifv && (v.ifinst[6:0] == 7'b1100011) && (m_bht[v.ifpc[5:2]] >= 2);
    chk("pred_taken", 64'(pred_taken), 64'(exp_pred));
    if (use_tbl) chk("tbl_pred", 64'(pred_taken), 64'(v.e_pred));

    if (v.rst) begin
      model_reset();
    end else begin
      res  = v.exv && v.exbr && !v.stall && !m_flushing;
      miss = res && (m_ex_pred != v.ext);
      ei   = int'(v.expc[5:2]);
      if (res) m_bht[ei] = v.ext ? ((m_bht[ei] < 3) ? m_bht[ei] + 1 : 3)
                                 : ((m_bht[ei] > 0) ? m_bht[ei] - 1 : 0);
      if (m_flushing) begin
        m_flushing = 0; m_pc_sel = 0; m_flush = 2'b00;
        m_id_pred = 0; m_ex_pred = 0;
      end else begin
        if (miss) begin
          m_flushing = 1; m_pc_sel = 1; m_flush = 2'b11;
          m_redir = v.ext ? v.extgt : v.expc + 32'd4;
          if (m_miss != 16'hFFFF) m_miss = m_miss + 16'd1;
        end
        if (!v.stall) begin
          m_ex_pred = m_id_pred;
          m_id_pred = exp_pred;
        end
      end
    end
    exp_q.push_back({m_pc_sel, m_flush, m_redir, m_miss});

    @(posedge clk);
    @(negedge clk);
    e = exp_q.pop_front();
    chk("pc_sel", 64'(pc_sel), 64'(e[50]));
    chk("flush", 64'(flush), 64'(e[49:48]));
    chk("redirect_pc", 64'(redirect_pc), 64'(e[47:16]));
    chk("miss_cnt", 64'(miss_cnt), 64'(e[15:0]));
    chk("state", 64'(dbg_state), 64'(m_flushing));
    for (int i = 0; i < 16; i++) begin
      act_bht[2*i +: 2] = dut.u_bht.cnt_q[i];
      exp_bht[2*i +: 2] = 2'(m_bht[i]);
    end
    chk("bht", 64'(act_bht), 64'(exp_bht));
    if (use_tbl) begin
      chk("tbl_pc_sel", 64'(pc_sel), 64'(v.e_pc_sel));
      chk("tbl_flush", 64'(flush), 64'(v.e_flush));
      chk("tbl_redirect", 64'(redirect_pc), 64'(v.e_redir));
      chk("tbl_miss_cnt", 64'(miss_cnt), 64'(v.e_miss));
      chk("tbl_cnt0", 64'(dut.u_bht.cnt_q[0]), 64'(v.e_cnt0));
    end
  endtask

  vec_t tbl [22];
  vec_t rv;

  initial begin
    rst = 1'b1; stall = 1'b0; if_valid = 1'b0; if_pc = '0; if_inst = NOP;
    ex_valid = 1'b0; ex_is_branch = 1'b0; ex_pc = '0; ex_taken = 1'b0; ex_target = '0;
    model_reset();

    //            rst stl ifv ifpc   ifinst exv exbr expc  ext extgt   pred sel fl  redir   miss cnt0
    tbl[0]  = mk(1, 0, 0, 0,     NOP, 0, 0, 0,     0, 0,      0, 0, 0, 0,      0, 1);
    tbl[1]  = mk(0, 0, 1, 'h40,  BR,  0, 0, 0,     0, 0,      0, 0, 0, 0,      0, 1);
    tbl[2]  = mk(0, 0, 1, 'h44,  NOP, 0, 0, 0,     0, 0,      0, 0, 0, 0,      0, 1);
    tbl[3]  = mk(0, 0, 1, 'h48,  NOP, 1, 1, 'h40,  1, 'h100,  0, 1, 3, 'h100,  1, 2);
    tbl[4]  = mk(0, 0, 0, 0,     NOP, 0, 0, 0,     0, 0,      0, 0, 0, 'h100,  1, 2);
    tbl[5]  = mk(0, 0, 1, 'h40,  BR,  0, 0, 0,     0, 0,      1, 0, 0, 'h100,  1, 2);
    tbl[6]  = mk(0, 0, 1, 'h40,  BR,  0, 0, 0,     0, 0,      1, 0, 0, 'h100,  1, 2);
    tbl[7]  = mk(0, 0, 1, 'h40,  BR,  1, 1, 'h40,  1, 'h100,  1, 0, 0, 'h100,  1, 3);
    tbl[8]  = mk(0, 0, 0, 0,     NOP, 1, 1, 'h40,  1, 'h100,  0, 0, 0, 'h100,  1, 3);
    tbl[9]  = mk(0, 0, 0, 0,     NOP, 1, 1, 'h40,  1, 'h100,  0, 0, 0, 'h100,  1, 3);
    tbl[10] = mk(0, 0, 1, 'h40,  BR,  0, 0, 0,     0, 0,      1, 0, 0, 'h100,  1, 3);
    tbl[11] = mk(0, 0, 0, 0,     NOP, 0, 0, 0,     0, 0,      0, 0, 0, 'h100,  1, 3);
    tbl[12] = mk(0, 0, 0, 0,     NOP, 1, 1, 'h40,  0, 'h100,  0, 1, 3, 'h44,   2, 2);
    tbl[13] = mk(0, 0, 0, 0,     NOP, 1, 1, 'h40,  1, 'h200,  0, 0, 0, 'h44,   2, 2);
    tbl[14] = mk(0, 0, 0, 0,     NOP, 1, 1, 'h40,  1, 'h200,  0, 1, 3, 'h200,  3, 3);
    tbl[15] = mk(0, 1, 0, 0,     NOP, 0, 0, 0,     0, 0,      0, 0, 0, 'h200,  3, 3);
    tbl[16] = mk(0, 0, 1, 'h40,  BR,  0, 0, 0,     0, 0,      1, 0, 0, 'h200,  3, 3);
    tbl[17] = mk(0, 0, 0, 0,     NOP, 0, 0, 0,     0, 0,      0, 0, 0, 'h200,  3, 3);
    tbl[18] = mk(0, 1, 0, 0,     NOP, 1, 1, 'h40,  0, 'h100,  0, 0, 0, 'h200,  3, 3);
    tbl[19] = mk(0, 0, 0, 0,     NOP, 1, 1, 'h40,  0, 'h100,  0, 1, 3, 'h44,   4, 2);
    tbl[20] = mk(1, 0, 0, 0,     NOP, 0, 0, 0,     0, 0,      0, 0, 0, 0,      0, 1);
    tbl[21] = mk(0, 0, 1, 'h40,  BR,  0, 0, 0,     0, 0,      0, 0, 0, 0,      0, 1);

    @(negedge clk);
    for (int i = 0; i < 22; i++) drive(tbl[i], 1'b1);

    // Not-taken recovery from the last word of the address space wraps to 0.
    drive(mk(0, 0, 0, 0, NOP, 1, 1, 32'hFFFF_FFFC, 1, 'h10, 0, 0, 0, 0, 0, 0), 1'b0);
    drive(mk(0, 0, 0, 0, NOP, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 1'b0);
    drive(mk(0, 0, 0, 0, NOP, 1, 1, 32'hFFFF_FFFC, 1, 'h10, 0, 0, 0, 0, 0, 0), 1'b0);
    drive(mk(0, 0, 0, 0, NOP, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 1'b0);
    drive(mk(0, 0, 1, 32'hFFFF_FFFC, BR, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 1'b0);
    drive(mk(0, 0, 0, 0, NOP, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 1'b0);
    drive(mk(0, 0, 0, 0, NOP, 1, 1, 32'hFFFF_FFFC, 0, 'h10, 0, 0, 0, 0, 0, 0), 1'b0);
    chk("wrap_redirect", 64'(redirect_pc), 64'h0);
    chk("wrap_flush", 64'(flush), 64'h3);
    drive(mk(0, 0, 0, 0, NOP, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 1'b0);

    for (int n = 0; n < 4000; n++) begin
      rv = mk(0, 0, 0, 0, NOP, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      rv.rst    = ($urandom_range(0, 299) == 0);
      rv.stall  = ($urandom_range(0, 4) == 0);
      rv.ifv    = ($urandom_range(0, 3) != 0);
      rv.ifpc   = ($urandom_range(0, 19) == 0) ? {$urandom} & 32'hFFFF_FFFC
                                              : {26'h0, 4'($urandom_range(0, 15)), 2'b00};
      rv.ifinst = ($urandom_range(0, 1) == 0) ? ({$urandom} & 32'hFFFF_FF80) | BR : {$urandom};
      rv.exv    = ($urandom_range(0, 3) != 0);
      rv.exbr   = ($urandom_range(0, 2) != 0);
      rv.expc   = ($urandom_range(0, 19) == 0) ? 32'hFFFF_FFFC
                                              : {26'h0, 4'($urandom_range(0, 15)), 2'b00};
      rv.ext    = 1'($urandom_range(0, 1));
      rv.extgt  = {$urandom};
      drive(rv, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/branch_pred_ctrl.md
Name: branch_pred_ctrl

Overview:
- Dynamic branch prediction and misprediction-recovery controller for the 5-stage RISC-V pipeline.
- Holds a branch history table (BHT) of 2-bit saturating counters and predicts conditional branches (opcode 7'b1100011) in IF.
- Carries each prediction down to EX and compares it with the resolved outcome.
- Sequences the redirect/flush of IF/ID through a small state machine. Drives the PC mux select and the 2-bit flush vector.

Parameters:
- BHT_ENTRIES, 16, number of 2-bit counters; power of two, at least 2.
- IDX_W, $clog2(BHT_ENTRIES), BHT index width; derived, never overridden.
- XLEN, 32, PC/instruction width.

Ports:
- clk  in  1  pipeline clock
- rst  in  1  synchronous, active-high reset
- stall  in  1  pipeline stall; freezes IF/ID/EX tracking
- if_valid  in  1  IF holds a valid instruction
- if_pc  in  XLEN  PC of the IF instruction
- if_inst  in  XLEN  instruction word in IF
- ex_valid  in  1  EX holds a valid instruction
- ex_is_branch  in  1  EX instruction is a conditional branch
- ex_pc  in  XLEN  PC of the EX branch
- ex_taken  in  1  resolved branch outcome from the ALU compare
- ex_target  in  XLEN  resolved branch target
- pred_taken  out  1  combinational IF prediction (1 = take predicted target)
- pc_sel  out  1  registered; 1 = fetch from redirect_pc
- redirect_pc  out  XLEN  registered recovery PC
- flush  out  2  registered; bit1 = flush IF/ID, bit0 = flush ID/EX
- miss_cnt  out  16  saturating mispredict counter

Behaviour:
- Reset (synchronous, rst=1 at posedge):
  - all BHT counters = 2'b01 (weakly not-taken)
  - id_pred, ex_pred, id_vld, ex_vld = 0
  - state = IDLE
  - pc_sel = 0, flush = 2'b00, redirect_pc = 0, miss_cnt = 0
  - Reset mid-FLUSH aborts recovery immediately.
- Index: idx = pc[IDX_W+1:2].
- Prediction:
  - pred_taken = if_valid && if_inst[6:0]==7'b1100011 && bht[idx(if_pc)][1].
  - Combinational, no latency.
- Tracking:
  - When !stall: id_pred<=pred_taken, id_vld<=if_valid; ex_pred<=id_pred, ex_vld<=id_vld.
  - When stall: hold.
  - Any cycle with flush!=0: id_* and ex_* are cleared to 0 on that edge; this overrides the shift.
- Resolution event: res = ex_valid && ex_is_branch && !stall && state==IDLE.
- BHT update on res, written at the next edge:
  - if ex_taken: counter at idx(ex_pc) increments, saturating at 2'b11
  - else: counter decrements, saturating at 2'b00
  - Same-cycle IF read of the same index sees the pre-update value.
- Mispredict: miss = res && (ex_pred != ex_taken). Next edge:
  - pc_sel <= 1
  - flush <= 2'b11
  - redirect_pc <= ex_taken ? ex_target : ex_pc + 4 (mod 2^XLEN)
  - miss_cnt <= miss_cnt + 1, saturating at 16'hFFFF
  - state <= FLUSH
- Correct prediction (res && !miss): counter update only; pc_sel, flush and state unchanged.
- Non-branch in EX: nothing changes.
- FSM:
  - IDLE -> FLUSH on miss.
  - FLUSH lasts exactly 1 cycle. pc_sel=1, flush=2'b11 are visible during it. Next edge: pc_sel<=0, flush<=2'b00, state<=IDLE.
  - While in FLUSH, res is suppressed, so wrong-path branches neither update the BHT nor trigger a second redirect.
- Stall while in FLUSH does not extend FLUSH.
- Back-to-back: a mispredict resolving in the first IDLE cycle after FLUSH is legal and re-enters FLUSH.

Decomposition:
- Shared package rv_pkg holds:
  - OPC_BRANCH = 7'b1100011
  - BHT_INIT = 2'b01
  - enum bp_state_t {IDLE, FLUSH}
  - FLUSH_ALL = 2'b11, FLUSH_NONE = 2'b00
- One natural sub-module: bht_table.
  - Counter array with one combinational read port and one saturating update port.
  - Synchronous reset to BHT_INIT.
- FSM, tracking registers and miss_cnt stay in branch_pred_ctrl.

Test Plan:
- Reset then read: if_inst opcode 1100011, any if_pc -> pred_taken=0; all counters=01; pc_sel=0, flush=00.
- Taken branch, cold predictor: pc=0x40 flows IF->EX with ex_taken=1, ex_target=0x100.
  - Cycle after EX: pc_sel=1, flush=11, redirect_pc=0x100, miss_cnt=1, counter[0]=10.
  - Following cycle: pc_sel=0, flush=00.
- Warm taken: repeat the same branch. Fetch of 0x40 -> pred_taken=1; resolves taken -> no flush, counter[0]=11. Two more taken resolutions -> counter stays 11.
- Predicted-taken but not-taken: counter=11, ex_taken=0, ex_pc=0x40 -> redirect_pc=0x44, flush=11, counter=10.
- Wrong-path suppression: a mispredicting branch in EX during the FLUSH cycle -> no BHT change, no extra redirect, miss_cnt unchanged.
- Stall/reset: a stall during resolution holds ex_pred and produces no update. Asserting rst during FLUSH -> next cycle pc_sel=0, flush=00, miss_cnt=0, BHT back to 01.
